// File: rtl/motor_cmd_ramp.sv
// Slew-limited speed/direction command stage feeding the motor PWM generator.
// Optional command watchdog is built when CMD_WDOG_EN is defined.
module motor_cmd_ramp #(
  parameter int STEP_DIV    = 10000,
  parameter int STEP_SIZE   = 4,
  parameter int REV_DWELL   = 100000,
  parameter int WDOG_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_spd,
  output logic       pwm_en,
  output logic       dir,
  output logic [7:0] spd_sel,
  output logic       at_target,
  output logic       wdog_trip
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (REV_DWELL > 1) ? $clog2(REV_DWELL) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(REV_DWELL - 1);
  localparam logic [7:0]    STEP_INC   = 8'(STEP_SIZE);

  state_t        state_r, state_s;
  logic [7:0]    cur_spd_r, cur_spd_s;
  logic [7:0]    tgt_spd_r, tgt_spd_s;
  logic          cur_dir_r, cur_dir_s;
  logic          tgt_dir_r, tgt_dir_s;
  logic [SW-1:0] step_cnt_r, step_cnt_s;
  logic [DW-1:0] dwell_cnt_r, dwell_cnt_s;
  logic          pwm_en_r;
  logic          accept_s;
  logic          wdog_fire_s;
  logic [7:0]    eff_spd_s;

  // One bounded step from cur toward eff; clamps to eff so it never overshoots or wraps.
  function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] eff);
    logic [7:0] res;
    if (eff > cur) begin
      if ((eff - cur) <= STEP_INC) res = eff;
      else                         res = cur + STEP_INC;
    end else begin
      if ((cur - eff) <= STEP_INC) res = eff;
      else                         res = cur - STEP_INC;
    end
    return res;
  endfunction

  assign cmd_ready = !rst && en && (state_r != DWELL);
  assign accept_s  = cmd_valid && cmd_ready;
  assign at_target = (cur_spd_r == tgt_spd_r) && (cur_dir_r == tgt_dir_r);
  assign spd_sel   = cur_spd_r;
  assign dir       = cur_dir_r;
  assign pwm_en    = pwm_en_r;

`ifdef CMD_WDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt_r;
  logic          wdog_trip_r;

  assign wdog_fire_s = en && !accept_s && (wdog_cnt_r == WDOG_LAST);
  assign wdog_trip   = wdog_trip_r;

  // Command-timeout counter and sticky trip flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_r  <= '0;
      wdog_trip_r <= 1'b0;
    end else if (!en || accept_s) begin
      wdog_cnt_r  <= '0;
      wdog_trip_r <= 1'b0;
    end else if (wdog_fire_s) begin
      wdog_cnt_r  <= '0;
      wdog_trip_r <= 1'b1;
    end else begin
      wdog_cnt_r  <= wdog_cnt_r + WW'(1);
    end
  end
`else
  logic unused_wdog_s;
  assign unused_wdog_s = (WDOG_CYCLES == 0);
  assign wdog_fire_s   = 1'b0;
  assign wdog_trip     = 1'b0;
`endif

  // Next-state, target update and ramp stepping
  always_comb begin
    state_s     = state_r;
    cur_spd_s   = cur_spd_r;
    cur_dir_s   = cur_dir_r;
    tgt_spd_s   = tgt_spd_r;
    tgt_dir_s   = tgt_dir_r;
    step_cnt_s  = step_cnt_r;
    dwell_cnt_s = dwell_cnt_r;

    if (accept_s) begin
      tgt_spd_s = cmd_spd;
      tgt_dir_s = cmd_dir;
    end else if (wdog_fire_s) begin
      tgt_spd_s = 8'd0;
    end else begin
      tgt_spd_s = tgt_spd_r;
    end

    // A pending reversal first ramps toward zero in the current direction.
    eff_spd_s = (tgt_dir_s == cur_dir_r) ? tgt_spd_s : 8'd0;

    if (!en) begin
      state_s     = HOLD;
      cur_spd_s   = 8'd0;
      tgt_spd_s   = 8'd0;
      tgt_dir_s   = cur_dir_r;
      step_cnt_s  = '0;
      dwell_cnt_s = '0;
    end else begin
      case (state_r)
        HOLD: begin
          step_cnt_s  = '0;
          dwell_cnt_s = '0;
          if (accept_s) begin
            if (cmd_dir == cur_dir_r) begin
              state_s = (cmd_spd != cur_spd_r) ? RAMP : HOLD;
            end else if (cur_spd_r == 8'd0) begin
              cur_dir_s = cmd_dir;
              state_s   = (cmd_spd != 8'd0) ? RAMP : HOLD;
            end else begin
              state_s = RAMP;
            end
          end else if (wdog_fire_s) begin
            state_s = (cur_spd_r != 8'd0) ? RAMP : HOLD;
          end else begin
            state_s = HOLD;
          end
        end
        RAMP: begin
          dwell_cnt_s = '0;
          if (step_cnt_r == STEP_LAST) begin
            step_cnt_s = '0;
            cur_spd_s  = ramp_step(cur_spd_r, eff_spd_s);
            if (cur_spd_s == eff_spd_s) begin
              state_s = (tgt_dir_s != cur_dir_r) ? DWELL : HOLD;
            end else begin
              state_s = RAMP;
            end
          end else begin
            step_cnt_s = step_cnt_r + SW'(1);
            state_s    = RAMP;
          end
        end
        DWELL: begin
          cur_spd_s  = 8'd0;
          step_cnt_s = '0;
          if (dwell_cnt_r == DWELL_LAST) begin
            dwell_cnt_s = '0;
            cur_dir_s   = tgt_dir_r;
            state_s     = (tgt_spd_r != 8'd0) ? RAMP : HOLD;
          end else begin
            dwell_cnt_s = dwell_cnt_r + DW'(1);
            state_s     = DWELL;
          end
        end
        default: begin
          state_s     = HOLD;
          cur_spd_s   = 8'd0;
          tgt_spd_s   = 8'd0;
          tgt_dir_s   = cur_dir_r;
          step_cnt_s  = '0;
          dwell_cnt_s = '0;
        end
      endcase
    end
  end

  // State and datapath registers; pwm_en follows the next speed so it lines up with spd_sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= HOLD;
      cur_spd_r   <= 8'd0;
      cur_dir_r   <= 1'b1;
      tgt_spd_r   <= 8'd0;
      tgt_dir_r   <= 1'b1;
      step_cnt_r  <= '0;
      dwell_cnt_r <= '0;
      pwm_en_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_spd_r   <= cur_spd_s;
      cur_dir_r   <= cur_dir_s;
      tgt_spd_r   <= tgt_spd_s;
      tgt_dir_r   <= tgt_dir_s;
      step_cnt_r  <= step_cnt_s;
      dwell_cnt_r <= dwell_cnt_s;
      pwm_en_r    <= en && (cur_spd_s != 8'd0);
    end
  end

endmodule
